// File: rtl/rle.sv
// Byte run-length encoder: reads a message from a shared single-port word RAM
// and writes (symbol, count) byte pairs back into the same RAM, packed LSB first.
module rle (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [31:0] message_addr,
    input  logic [31:0] message_size,
    input  logic [31:0] rle_addr,
    output logic [31:0] rle_size,
    output logic        done,
    output logic        port_A_clk,
    output logic [31:0] port_A_data_in,
    input  logic [31:0] port_A_data_out,
    output logic [15:0] port_A_addr,
    output logic        port_A_we
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SCAN,
        S_WRITE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state, state_d;
    state_t      ret_state, ret_d;
    state_t      after_scan;

    logic [15:0] rd_addr;
    logic [15:0] wr_addr;
    logic [31:0] left;
    logic [31:0] word_q;
    logic [31:0] acc;
    logic [1:0]  idx;
    logic [7:0]  sym;
    logic [7:0]  cnt;
    logic [7:0]  cur_byte;
    logic        have_run;
    logic        acc_half;
    logic        extend;
    logic        emit;
    logic        unused_addr_bits;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    endfunction

    // A run stops growing once its count byte would overflow.
    function automatic logic run_saturated(input logic [7:0] c);
        run_saturated = (c == 8'hFF);
    endfunction

    assign unused_addr_bits = ^{message_addr[31:16], message_addr[1:0],
                                rle_addr[31:16], rle_addr[1:0]};

    assign port_A_clk     = clk;
    assign port_A_we      = (state == S_WRITE);
    assign port_A_addr    = port_A_we ? wr_addr : rd_addr;
    assign port_A_data_in = acc;
    assign done           = (state == S_DONE);

    always_comb begin
        cur_byte   = byte_sel(word_q, idx);
        extend     = have_run && (cur_byte == sym) && !run_saturated(cnt);
        emit       = 1'b0;
        state_d    = state;
        ret_d      = S_IDLE;

        // Where scanning continues once the current byte is consumed.
        if (left == 32'd1)
            after_scan = S_FLUSH;
        else if (idx == 2'd3)
            after_scan = S_READ;
        else
            after_scan = S_SCAN;

        case (state)
            S_IDLE: begin
                if (start)
                    state_d = (message_size == 32'd0) ? S_FLUSH : S_READ;
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_SCAN;
            S_SCAN: begin
                emit    = have_run && !extend;
                ret_d   = after_scan;
                state_d = (emit && acc_half) ? S_WRITE : after_scan;
            end
            S_WRITE: state_d = ret_state;
            S_FLUSH: begin
                ret_d = S_FLUSH;
                if (have_run) begin
                    emit    = 1'b1;
                    state_d = acc_half ? S_WRITE : S_FLUSH;
                end else if (acc_half) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
        end else begin
            state <= state_d;
            if (state_d == S_WRITE)
                ret_state <= ret_d;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_addr  <= 16'd0;
            wr_addr  <= 16'd0;
            left     <= 32'd0;
            word_q   <= 32'd0;
            acc      <= 32'd0;
            idx      <= 2'd0;
            sym      <= 8'd0;
            cnt      <= 8'd0;
            have_run <= 1'b0;
            acc_half <= 1'b0;
            rle_size <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_addr  <= {message_addr[15:2], 2'b00};
                        wr_addr  <= {rle_addr[15:2], 2'b00};
                        left     <= message_size;
                        rle_size <= 32'd0;
                        have_run <= 1'b0;
                        acc_half <= 1'b0;
                        idx      <= 2'd0;
                    end
                end
                S_READ: rd_addr <= rd_addr + 16'd4;
                S_WAIT: begin
                    word_q <= port_A_data_out;
                    idx    <= 2'd0;
                end
                S_SCAN: begin
                    idx  <= idx + 2'd1;
                    left <= left - 32'd1;
                    if (extend) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        sym      <= cur_byte;
                        cnt      <= 8'd1;
                        have_run <= 1'b1;
                    end
                end
                S_WRITE: wr_addr <= wr_addr + 16'd4;
                S_FLUSH: begin
                    have_run <= 1'b0;
                    // A lone low half is written as-is; its upper half is already zero.
                    if (!have_run && acc_half)
                        acc_half <= 1'b0;
                end
                default: ;
            endcase

            if (emit) begin
                rle_size <= rle_size + 32'd2;
                if (acc_half) begin
                    acc[31:16] <= {cnt, sym};
                    acc_half   <= 1'b0;
                end else begin
                    acc      <= {16'h0000, cnt, sym};
                    acc_half <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rle.sv
// Directed bench for rle: behavioural word RAM, hand-computed frames,
// bus monitors for alignment, write window, write count and done pulses.
module tb_rle;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [31:0] message_addr;
    logic [31:0] message_size;
    logic [31:0] rle_addr;
    logic [31:0] rle_size;
    logic        done;
    logic        port_A_clk;
    logic [31:0] port_A_data_in;
    logic [31:0] port_A_data_out;
    logic [15:0] port_A_addr;
    logic        port_A_we;

    logic [31:0] mem [0:1023];
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;

    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          we_cnt = 0;
    int          misalign_cnt = 0;
    int          oob_cnt = 0;
    logic [15:0] win_lo = 16'd0;
    logic [15:0] win_hi = 16'd0;
    logic [7:0]  f2_bytes [0:51];

    always #5 clk = ~clk;

    rle dut (
        .clk             (clk),
        .nreset          (nreset),
        .start           (start),
        .message_addr    (message_addr),
        .message_size    (message_size),
        .rle_addr        (rle_addr),
        .rle_size        (rle_size),
        .done            (done),
        .port_A_clk      (port_A_clk),
        .port_A_data_in  (port_A_data_in),
        .port_A_data_out (port_A_data_out),
        .port_A_addr     (port_A_addr),
        .port_A_we       (port_A_we)
    );

    // RAM: one-cycle registered read, write at the edge where we=1.
    always @(posedge clk) begin
        if (ld_en)
            mem[ld_idx] <= ld_data;
        else if (port_A_we)
            mem[port_A_addr[11:2]] <= port_A_data_in;
        port_A_data_out <= mem[port_A_addr[11:2]];
    end

    always @(negedge clk) begin
        if (done)
            done_cnt <= done_cnt + 1;
        if (port_A_we)
            we_cnt <= we_cnt + 1;
        if (port_A_addr[1:0] != 2'b00)
            misalign_cnt <= misalign_cnt + 1;
        if (port_A_we && (port_A_addr < win_lo || port_A_addr >= win_hi))
            oob_cnt <= oob_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic [15:0] a, input logic [31:0] v);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_idx  = a[11:2];
        ld_data = v;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    function automatic logic [31:0] rd_word(input logic [15:0] a);
        return mem[a[11:2]];
    endfunction

    // Frame 2 pair p is symbol p+1 with count 2 for the first 13 runs, else 1.
    function automatic logic [31:0] f2_word(input int k);
        int p0, p1;
        p0 = 2 * k;
        p1 = 2 * k + 1;
        return {8'((p1 < 13) ? 2 : 1), 8'(p1 + 1), 8'((p0 < 13) ? 2 : 1), 8'(p0 + 1)};
    endfunction

    task automatic run_frame(input logic [15:0] maddr, input logic [31:0] msize,
                             input logic [15:0] raddr, input int hold);
        int c0;
        int t;
        c0 = done_cnt;
        @(negedge clk);
        message_addr = {16'h0000, maddr};
        message_size = msize;
        rle_addr     = {16'h0000, raddr};
        start        = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 0)
                check("size_clear", rle_size, 32'd0);
        end
        start = 1'b0;
        t = 0;
        while (done_cnt == c0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check("done_pulses", 32'(done_cnt - c0), 32'd1);
    endtask

    task automatic load_frame1();
        logic [7:0] s;
        for (int r = 0; r < 6; r++) begin
            s = 8'(8'h11 * (r + 1));
            load_word(16'(8 * r), {4{s}});
            load_word(16'(8 * r + 4), {4{s}});
        end
    endtask

    task automatic check_frame1(input string tag);
        check({tag, "_size"}, rle_size, 32'd12);
        check({tag, "_w0"}, rd_word(16'h00C8), 32'h08220811);
        check({tag, "_w1"}, rd_word(16'h00CC), 32'h08440833);
        check({tag, "_w2"}, rd_word(16'h00D0), 32'h08660855);
        check({tag, "_guard"}, rd_word(16'h00D4), 32'hDEADBEEF);
    endtask

    initial begin
        int w0, d0, pos;
        nreset       = 1'b0;
        start        = 1'b0;
        message_addr = 32'd0;
        message_size = 32'd0;
        rle_addr     = 32'd0;
        ld_en        = 1'b0;
        ld_idx       = 10'd0;
        ld_data      = 32'd0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check("rst_size", rle_size, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wdata", port_A_data_in, 32'd0);
        check("rst_addr", 32'(port_A_addr), 32'd0);
        check("rst_we", 32'(port_A_we), 32'd0);
        check("ram_clk_lo", 32'(port_A_clk), 32'd0);
        @(posedge clk);
        #1;
        check("ram_clk_hi", 32'(port_A_clk), 32'd1);

        // Frame 1: six runs of eight bytes.
        load_frame1();
        for (int k = 0; k < 4; k++)
            load_word(16'(16'h00C8 + 4 * k), 32'hDEADBEEF);
        win_lo = 16'h00C8;
        win_hi = 16'h00D4;
        w0 = we_cnt;
        run_frame(16'h0000, 32'd48, 16'h00C8, 1);
        check_frame1("f1");
        check("f1_writes", 32'(we_cnt - w0), 32'd3);

        // Frame 2: 38 runs in 51 bytes; the fourth byte of the last word is unused.
        pos = 0;
        for (int r = 0; r < 38; r++)
            for (int k = 0; k < ((r < 13) ? 2 : 1); k++) begin
                f2_bytes[pos] = 8'(r + 1);
                pos++;
            end
        f2_bytes[51] = 8'h00;
        for (int w = 0; w < 13; w++)
            load_word(16'(16'h0030 + 4 * w),
                      {f2_bytes[4*w+3], f2_bytes[4*w+2], f2_bytes[4*w+1], f2_bytes[4*w]});
        load_word(16'h0178, 32'hDEADBEEF);
        repeat (10) @(negedge clk);
        win_lo = 16'h012C;
        win_hi = 16'h0178;
        w0 = we_cnt;
        run_frame(16'h0030, 32'd51, 16'h012C, 1);
        check("f2_size", rle_size, 32'd76);
        check("f2_writes", 32'(we_cnt - w0), 32'd19);
        check("f2_w0", rd_word(16'h012C), 32'h02020201);
        check("f2_w6", rd_word(16'h0144), 32'h010E020D);
        check("f2_w18", rd_word(16'h0174), 32'h01260125);
        for (int k = 0; k < 19; k++)
            check($sformatf("f2_word%0d", k), rd_word(16'(16'h012C + 4 * k)), f2_word(k));
        check("f2_guard", rd_word(16'h0178), 32'hDEADBEEF);

        // Long run of 300 identical bytes splits into 255 + 45.
        for (int w = 0; w < 75; w++)
            load_word(16'(16'h0400 + 4 * w), 32'hABABABAB);
        load_word(16'h0704, 32'hDEADBEEF);
        win_lo = 16'h0700;
        win_hi = 16'h0704;
        w0 = we_cnt;
        run_frame(16'h0400, 32'd300, 16'h0700, 1);
        check("long_size", rle_size, 32'd4);
        check("long_w0", rd_word(16'h0700), 32'h2DABFFAB);
        check("long_writes", 32'(we_cnt - w0), 32'd1);
        check("long_guard", rd_word(16'h0704), 32'hDEADBEEF);

        // Odd pair count: AA AA BB CC.
        load_word(16'h0600, 32'hCCBBAAAA);
        load_word(16'h0710, 32'hDEADBEEF);
        load_word(16'h0714, 32'hDEADBEEF);
        load_word(16'h0718, 32'hDEADBEEF);
        win_lo = 16'h0710;
        win_hi = 16'h0718;
        w0 = we_cnt;
        run_frame(16'h0600, 32'd4, 16'h0710, 1);
        check("odd_size", rle_size, 32'd6);
        check("odd_w0", rd_word(16'h0710), 32'h01BB02AA);
        check("odd_w1", rd_word(16'h0714), 32'h000001CC);
        check("odd_writes", 32'(we_cnt - w0), 32'd2);
        check("odd_guard", rd_word(16'h0718), 32'hDEADBEEF);

        // Empty message with start held for two cycles.
        win_lo = 16'h0720;
        win_hi = 16'h0720;
        w0 = we_cnt;
        run_frame(16'h0000, 32'd0, 16'h0720, 2);
        check("zero_size", rle_size, 32'd0);
        check("zero_writes", 32'(we_cnt - w0), 32'd0);

        // Reset while scanning frame 1, then rerun it.
        for (int k = 0; k < 4; k++)
            load_word(16'(16'h00C8 + 4 * k), 32'hDEADBEEF);
        win_lo = 16'h00C8;
        win_hi = 16'h00D4;
        @(negedge clk);
        message_addr = 32'h0000_0000;
        message_size = 32'd48;
        rle_addr     = 32'h0000_00C8;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        check("mid_rst_size", rle_size, 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_wdata", port_A_data_in, 32'd0);
        check("mid_rst_addr", 32'(port_A_addr), 32'd0);
        check("mid_rst_we", 32'(port_A_we), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        w0 = we_cnt;
        d0 = done_cnt;
        repeat (8) @(negedge clk);
        check("post_rst_writes", 32'(we_cnt - w0), 32'd0);
        check("post_rst_done", 32'(done_cnt - d0), 32'd0);
        run_frame(16'h0000, 32'd48, 16'h00C8, 1);
        check_frame1("rerun");

        check("addr_aligned", 32'(misalign_cnt), 32'd0);
        check("write_window", 32'(oob_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
